fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 8'h80, first program address and PC value after reset.
REQ-002 Parameter END_PC, default 8'h99, last valid program address.
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-005 run  input  1  start request; leaves IDLE.
REQ-006 mem_pc  output  8  address to mem_instr; equals internal fetch PC (fpc) at all times.
REQ-007 mem_instr  input  8  instruction memory read data, valid the cycle after the edge that sampled mem_pc.
REQ-008 instr  output  8  instruction to decode.
REQ-009 instr_pc  output  8  address of instr.
REQ-010 instr_valid  output  1  instr/instr_pc valid this cycle.
REQ-011 instr_ready  input  1  decode accepts; transfer occurs on an edge where instr_valid && instr_ready.
REQ-012 redirect  input  1  branch/jump taken; flush and restart at redirect_pc.
REQ-013 redirect_pc  input  8  target address.
REQ-014 halted  output  1  fetch stopped and fully drained.

Function
REQ-015 States SHALL be IDLE, FETCH, HALT; IDLE->FETCH on run=1; FETCH->HALT per REQ-021; FETCH/HALT->FETCH on redirect=1; IDLE ignores redirect.
REQ-016 issue = (state==FETCH) && !redirect && (fpc<=END_PC) && !skid_valid && (!in_flight || instr_ready).
REQ-017 On issue edge: in_flight<=1, inflight_pc<=fpc, fpc<=fpc+1 (8-bit); with no issue, in_flight<=0 unless the item is held per REQ-019.
REQ-018 instr_valid = !redirect && (skid_valid || in_flight); instr/instr_pc from skid when skid_valid, else mem_instr/inflight_pc.
REQ-019 Edge with in_flight && !skid_valid && !instr_ready && !redirect: skid_data<=mem_instr, skid_pc<=inflight_pc, skid_valid<=1, in_flight<=0.
REQ-020 Edge with skid_valid && instr_ready: skid_valid<=0; no issue that edge; at most one instruction buffered ever.
REQ-021 In FETCH with fpc>END_PC and no redirect: no issue, state<=HALT; pending in_flight/skid items still delivered in HALT.
REQ-022 halted = (state==HALT) && !in_flight && !skid_valid.
REQ-023 Redirect edge: fpc<=redirect_pc, in_flight<=0, skid_valid<=0, state<=FETCH; nothing issued that edge; first target fetch issues next edge; instr_valid=0 throughout redirect cycle.
REQ-024 redirect_pc below RESET_PC SHALL be fetched normally (no low-range check); redirect_pc>END_PC SHALL enter HALT on the next edge without issuing.
REQ-025 Redirect with instr_ready=1 in the same cycle SHALL transfer nothing (instr_valid low).
REQ-026 Sustained throughput SHALL be one instruction per cycle with instr_ready held 1; first instr_valid one cycle after the first issue edge.

Reset
REQ-027 reset=1 at an edge SHALL force state=IDLE, fpc=RESET_PC, in_flight=0, skid_valid=0, regardless of state or in-flight work; outputs then mem_pc=8'h80, instr_valid=0, halted=0.
REQ-028 reset SHALL take priority over run and redirect at the same edge.

Verification
REQ-029 Reset, run=1 one cycle, instr_ready=1 -> instr_pc 8'h80..8'h99 delivered on 26 consecutive cycles, mem_instr at 8'h80 is 8'hAA, halted=1 one cycle after the 8'h99 transfer.
REQ-030 Stream running, instr_ready=0 for 3 cycles at instr_pc 8'h85 -> 8'h85 held stable via skid, mem_pc frozen at 8'h86, on release 8'h85 then 8'h86 delivered, no loss or duplicate.
REQ-031 redirect=1, redirect_pc=8'h8A while 8'h90 in flight -> instr_valid=0 that cycle, 8'h90 never delivered, next delivered instr_pc=8'h8A.
REQ-032 In HALT, redirect_pc=8'h80 -> halted drops, stream restarts from 8'h80.
REQ-033 reset asserted mid-stream with skid full -> next cycle instr_valid=0, mem_pc=8'h80, state IDLE until run.
REQ-034 redirect_pc=8'hA0 -> no instr_valid, halted=1 two edges later.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues sequential addresses to a one-cycle-latency
// instruction memory and hands instructions to decode through a one-entry skid buffer.
module fetch_ctrl #(
   parameter logic [7:0] RESET_PC = 8'h80,
   parameter logic [7:0] END_PC   = 8'h99
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       run,
   output logic [7:0] mem_pc,
   input  logic [7:0] mem_instr,
   output logic [7:0] instr,
   output logic [7:0] instr_pc,
   output logic       instr_valid,
   input  logic       instr_ready,
   input  logic       redirect,
   input  logic [7:0] redirect_pc,
   output logic       halted
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t     state;
   logic [7:0] fpc;
   logic       in_flight;
   logic [7:0] inflight_pc;
   logic       skid_valid;
   logic [7:0] skid_data;
   logic [7:0] skid_pc;
   logic       issue;

   // A new fetch may only start when its result has somewhere to go next cycle.
   assign issue = (state == FETCH) && !redirect && (fpc <= END_PC) && !skid_valid &&
                  (!in_flight || instr_ready);

   assign mem_pc      = fpc;
   assign instr_valid = !redirect && (skid_valid || in_flight);
   assign instr       = skid_valid ? skid_data : mem_instr;
   assign instr_pc    = skid_valid ? skid_pc : inflight_pc;
   assign halted      = (state == HALT) && !in_flight && !skid_valid;

   // NOTE: only control state is reset; the address/data payload registers are
   // qualified by in_flight/skid_valid, so their contents after reset never matter.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         fpc        <= RESET_PC;
         in_flight  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (redirect && (state != IDLE)) begin
         // Flush everything in the pipe; the target is fetched on the following edge.
         state      <= FETCH;
         fpc        <= redirect_pc;
         in_flight  <= 1'b0;
         skid_valid <= 1'b0;
      end else begin
         case (state)
            IDLE:    if (run) state <= FETCH;
            FETCH:   if (fpc > END_PC) state <= HALT;
            default: state <= state;
         endcase

         if (issue) begin
            in_flight   <= 1'b1;
            inflight_pc <= fpc;
            fpc         <= fpc + 8'd1;
         end else if (in_flight && !skid_valid && !instr_ready) begin
            // Memory data is only valid for one cycle, so park it before it is lost.
            skid_data  <= mem_instr;
            skid_pc    <= inflight_pc;
            skid_valid <= 1'b1;
            in_flight  <= 1'b0;
         end else begin
            in_flight <= 1'b0;
         end

         if (skid_valid && instr_ready) skid_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: stimulus pushes expected (pc, instr) pairs,
// a monitor pops and compares on every decode transfer.
module tb_fetch_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       run = 1'b0;
   logic [7:0] mem_pc;
   logic [7:0] mem_instr = 8'h00;
   logic [7:0] instr;
   logic [7:0] instr_pc;
   logic       instr_valid;
   logic       instr_ready = 1'b1;
   logic       redirect = 1'b0;
   logic [7:0] redirect_pc = 8'h00;
   logic       halted;

   typedef struct {
      logic [7:0] pc;
      logic [7:0] data;
   } item_t;

   item_t exp_q[$];
   int    xfer_cyc_q[$];
   int    cyc = 0;
   int    n_checks = 0;
   int    n_fail = 0;

   fetch_ctrl dut (
      .clock       (clock),
      .reset       (reset),
      .run         (run),
      .mem_pc      (mem_pc),
      .mem_instr   (mem_instr),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halted      (halted)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Instruction memory: registered read, content is address ^ 8'h2A (8'h80 -> 8'hAA).
   always @(posedge clock) mem_instr <= mem_pc ^ 8'h2A;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic push_range(input int lo, input int hi);
      for (int a = lo; a <= hi; a++) begin
         item_t it;
         it.pc   = 8'(a);
         it.data = 8'(a) ^ 8'h2A;
         exp_q.push_back(it);
      end
   endtask

   task automatic wait_pc(input string name, input logic [7:0] pc, input int limit);
      logic found = 1'b0;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (instr_valid && instr_pc == pc) begin
            found = 1'b1;
            break;
         end
      end
      check(name, 32'(found), 32'd1);
   endtask

   task automatic wait_halted(input string name, input int limit);
      logic found = 1'b0;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (halted) begin
            found = 1'b1;
            break;
         end
      end
      check(name, 32'(found), 32'd1);
   endtask

   // Monitor: every transfer must match the head of the scoreboard.
   always @(negedge clock) begin
      if (!reset && instr_valid && instr_ready) begin
         check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            item_t it;
            it = exp_q.pop_front();
            check("xfer_pc", 32'(instr_pc), 32'(it.pc));
            check("xfer_instr", 32'(instr), 32'(it.data));
         end
         xfer_cyc_q.push_back(cyc);
      end
   end

   initial begin
      int c_run;
      int h_cyc;

      // Reset state
      tick(2);
      reset = 1'b0;
      #1;
      check("rst_mem_pc", 32'(mem_pc), 32'h80);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);

      // Full stream 80..99 with decode always ready
      xfer_cyc_q.delete();
      push_range(8'h80, 8'h99);
      run = 1'b1;
      tick();
      c_run = cyc;
      run = 1'b0;
      wait_halted("halt_after_stream", 60);
      h_cyc = cyc;
      check("stream_count", 32'(xfer_cyc_q.size()), 32'd26);
      if (xfer_cyc_q.size() == 26) begin
         check("first_valid_latency", 32'(xfer_cyc_q[0]), 32'(c_run + 1));
         check("stream_back_to_back", 32'(xfer_cyc_q[25] - xfer_cyc_q[0]), 32'd25);
         check("halt_one_after_last", 32'(h_cyc), 32'(xfer_cyc_q[25] + 1));
      end
      check("sb_drained_1", 32'(exp_q.size()), 32'd0);

      // Redirect out of HALT back to 80, then stall decode at 85
      redirect = 1'b1;
      redirect_pc = 8'h80;
      #1;
      check("halt_redir_valid", 32'(instr_valid), 32'd0);
      tick();
      redirect = 1'b0;
      #1;
      check("halt_redir_halted", 32'(halted), 32'd0);
      push_range(8'h80, 8'h8F);
      wait_pc("wait_85", 8'h85, 20);
      instr_ready = 1'b0;
      #1;
      check("stall_mem_pc_0", 32'(mem_pc), 32'h86);
      for (int i = 1; i < 3; i++) begin
         tick();
         check("stall_valid", 32'(instr_valid), 32'd1);
         check("stall_pc", 32'(instr_pc), 32'h85);
         check("stall_instr", 32'(instr), 32'h85 ^ 32'h2A);
         check("stall_mem_pc", 32'(mem_pc), 32'h86);
      end
      instr_ready = 1'b1;

      // Redirect to 8A while 90 is presented; 90 must never transfer
      wait_pc("wait_90", 8'h90, 30);
      redirect = 1'b1;
      redirect_pc = 8'h8A;
      #1;
      check("redir_valid_low", 32'(instr_valid), 32'd0);
      check("sb_drained_2", 32'(exp_q.size()), 32'd0);
      push_range(8'h8A, 8'h99);
      tick();
      redirect = 1'b0;
      wait_halted("halt_after_redir", 60);
      check("sb_drained_3", 32'(exp_q.size()), 32'd0);

      // Redirect past END_PC: halts without issuing
      redirect = 1'b1;
      redirect_pc = 8'hA0;
      tick();
      redirect = 1'b0;
      #1;
      check("hi_redir_halted_0", 32'(halted), 32'd0);
      check("hi_redir_valid_0", 32'(instr_valid), 32'd0);
      tick();
      check("hi_redir_halted_1", 32'(halted), 32'd1);
      check("hi_redir_valid_1", 32'(instr_valid), 32'd0);

      // Reset with the skid buffer full
      redirect = 1'b1;
      redirect_pc = 8'h80;
      tick();
      redirect = 1'b0;
      push_range(8'h80, 8'h83);
      wait_pc("wait_84", 8'h84, 20);
      instr_ready = 1'b0;
      tick();
      check("skid_full_pc", 32'(instr_pc), 32'h84);
      check("skid_full_valid", 32'(instr_valid), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      instr_ready = 1'b1;
      #1;
      check("mid_rst_valid", 32'(instr_valid), 32'd0);
      check("mid_rst_mem_pc", 32'(mem_pc), 32'h80);
      check("mid_rst_halted", 32'(halted), 32'd0);
      check("sb_drained_4", 32'(exp_q.size()), 32'd0);
      tick(3);
      check("idle_hold_mem_pc", 32'(mem_pc), 32'h80);
      check("idle_hold_valid", 32'(instr_valid), 32'd0);

      // Reset wins over run and redirect on the same edge
      reset = 1'b1;
      run = 1'b1;
      redirect = 1'b1;
      redirect_pc = 8'h55;
      tick();
      reset = 1'b0;
      run = 1'b0;
      redirect = 1'b0;
      #1;
      check("prio_mem_pc", 32'(mem_pc), 32'h80);
      tick(2);
      check("prio_idle_mem_pc", 32'(mem_pc), 32'h80);
      check("prio_idle_valid", 32'(instr_valid), 32'd0);

      // Redirect below RESET_PC is fetched normally
      push_range(8'h80, 8'h81);
      run = 1'b1;
      tick();
      run = 1'b0;
      wait_pc("wait_82", 8'h82, 20);
      redirect = 1'b1;
      redirect_pc = 8'h7E;
      push_range(8'h7E, 8'h99);
      tick();
      redirect = 1'b0;
      wait_halted("halt_after_low_redir", 80);
      check("sb_drained_5", 32'(exp_q.size()), 32'd0);

      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
